// File: rtl/siteswap_player.sv
// Siteswap pattern player: steps a latched juggling pattern one throw per beat and
// tracks ball identities through a circular landing schedule indexed by beat count.
module siteswap_player #(
    parameter int MAX_LEN = 7,
    parameter int SLOTS   = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 new_beat,
    input  logic [MAX_LEN*3-1:0] pattern_in,
    input  logic [2:0]           pattern_length,
    input  logic [2:0]           num_balls_in,
    input  logic                 pattern_valid_in,
    input  logic                 start_in,
    input  logic                 stop_in,
    output logic                 running_out,
    output logic                 throw_valid_out,
    output logic [2:0]           throw_height_out,
    output logic [2:0]           throw_ball_out,
    output logic                 hand_out,
    output logic [2:0]           beat_index_out,
    output logic                 error_out
);

    localparam int TW = $clog2(SLOTS);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [2:0]       pat_q [MAX_LEN];
    logic [2:0]       pat_d [MAX_LEN];
    logic [2:0]       len_q, len_d;
    logic [2:0]       balls_q, balls_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       launched_q, launched_d;
    logic [TW-1:0]    t_q, t_d;
    logic             hand_q, hand_d;
    logic [SLOTS-1:0] occ_q, occ_d;
    logic [2:0]       slot_id_q [SLOTS];
    logic [2:0]       slot_id_d [SLOTS];

    logic             valid_q, valid_d;
    logic [2:0]       height_q, height_d;
    logic [2:0]       ball_q, ball_d;
    logic             hand_out_q, hand_out_d;
    logic [2:0]       index_q, index_d;
    logic             err_q, err_d;

    logic [2:0]       h;
    logic             landing;
    logic [2:0]       land_id;
    logic [TW:0]      sum;
    logic [TW-1:0]    dest;
    logic             start_ok;

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        balls_d    = balls_q;
        idx_d      = idx_q;
        launched_d = launched_q;
        t_d        = t_q;
        hand_d     = hand_q;
        occ_d      = occ_q;
        slot_id_d  = slot_id_q;
        valid_d    = 1'b0;
        height_d   = height_q;
        ball_d     = ball_q;
        hand_out_d = hand_out_q;
        index_d    = index_q;
        err_d      = err_q;

        h        = pat_q[idx_q];
        landing  = occ_q[t_q];
        land_id  = slot_id_q[t_q];
        start_ok = start_in && pattern_valid_in && (pattern_length != 3'd0);

        // Heights are always below SLOTS, so a single wrap keeps the slot in range.
        sum = (TW+1)'(t_q) + (TW+1)'(h);
        if (sum >= (TW+1)'(SLOTS)) begin
            sum = sum - (TW+1)'(SLOTS);
        end
        dest = sum[TW-1:0];

        if (stop_in) begin
            state_d = S_IDLE;
            occ_d   = '0;
        end else if (start_ok) begin
            state_d = S_RUN;
            for (int i = 0; i < MAX_LEN; i++) begin
                pat_d[i] = pattern_in[3*i +: 3];
            end
            len_d      = pattern_length;
            balls_d    = num_balls_in;
            occ_d      = '0;
            idx_d      = '0;
            t_d        = '0;
            launched_d = '0;
            err_d      = 1'b0;
            hand_d     = 1'b1;
        end else if (new_beat && (state_q == S_RUN)) begin
            height_d   = h;
            hand_out_d = hand_q;
            index_d    = idx_q;
            ball_d     = 3'd0;

            idx_d  = (idx_q == len_q - 3'd1) ? 3'd0 : idx_q + 3'd1;
            t_d    = (t_q == TW'(SLOTS - 1)) ? '0 : t_q + TW'(1);
            hand_d = ~hand_q;

            if (landing) begin
                occ_d[t_q] = 1'b0;
                if (h != 3'd0) begin
                    valid_d         = 1'b1;
                    ball_d          = land_id;
                    occ_d[dest]     = 1'b1;
                    slot_id_d[dest] = land_id;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    occ_d   = '0;
                end
            end else if (h != 3'd0) begin
                if (launched_q < balls_q) begin
                    valid_d         = 1'b1;
                    ball_d          = launched_q;
                    launched_d      = launched_q + 3'd1;
                    occ_d[dest]     = 1'b1;
                    slot_id_d[dest] = launched_q;
                end else begin
                    // Every ball is already in the air yet nothing lands: pattern is inconsistent.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    occ_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            for (int i = 0; i < MAX_LEN; i++) begin
                pat_q[i] <= 3'd0;
            end
            len_q      <= '0;
            balls_q    <= '0;
            idx_q      <= '0;
            launched_q <= '0;
            t_q        <= '0;
            hand_q     <= 1'b0;
            occ_q      <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_id_q[i] <= 3'd0;
            end
            valid_q    <= 1'b0;
            height_q   <= '0;
            ball_q     <= '0;
            hand_out_q <= 1'b0;
            index_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            balls_q    <= balls_d;
            idx_q      <= idx_d;
            launched_q <= launched_d;
            t_q        <= t_d;
            hand_q     <= hand_d;
            occ_q      <= occ_d;
            slot_id_q  <= slot_id_d;
            valid_q    <= valid_d;
            height_q   <= height_d;
            ball_q     <= ball_d;
            hand_out_q <= hand_out_d;
            index_q    <= index_d;
            err_q      <= err_d;
        end
    end

    assign running_out      = (state_q == S_RUN);
    assign throw_valid_out  = valid_q;
    assign throw_height_out = height_q;
    assign throw_ball_out   = ball_q;
    assign hand_out         = hand_out_q;
    assign beat_index_out   = index_q;
    assign error_out        = err_q;

endmodule

// File: tb/tb_siteswap_player.sv
// Directed bench for siteswap_player: hand-computed throw sequences, error and control cases.
module tb_siteswap_player;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        new_beat;
    logic [20:0] pattern_in;
    logic [2:0]  pattern_length;
    logic [2:0]  num_balls_in;
    logic        pattern_valid_in;
    logic        start_in;
    logic        stop_in;
    logic        running_out;
    logic        throw_valid_out;
    logic [2:0]  throw_height_out;
    logic [2:0]  throw_ball_out;
    logic        hand_out;
    logic [2:0]  beat_index_out;
    logic        error_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    siteswap_player #(.MAX_LEN(7), .SLOTS(8)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .new_beat         (new_beat),
        .pattern_in       (pattern_in),
        .pattern_length   (pattern_length),
        .num_balls_in     (num_balls_in),
        .pattern_valid_in (pattern_valid_in),
        .start_in         (start_in),
        .stop_in          (stop_in),
        .running_out      (running_out),
        .throw_valid_out  (throw_valid_out),
        .throw_height_out (throw_height_out),
        .throw_ball_out   (throw_ball_out),
        .hand_out         (hand_out),
        .beat_index_out   (beat_index_out),
        .error_out        (error_out)
    );

    function automatic logic [20:0] pk(input logic [2:0] a0, a1, a2, a3, a4);
        return {6'd0, a4, a3, a2, a1, a0};
    endfunction

    task automatic do_beat();
        @(negedge clk_in);
        new_beat = 1'b1;
        @(negedge clk_in);
        new_beat = 1'b0;
    endtask

    task automatic do_start(input logic [20:0] pat, input logic [2:0] len, input logic [2:0] nb);
        @(negedge clk_in);
        pattern_in       = pat;
        pattern_length   = len;
        num_balls_in     = nb;
        pattern_valid_in = 1'b1;
        start_in         = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; new_beat = 1'b0; pattern_in = '0; pattern_length = '0;
        num_balls_in = '0; pattern_valid_in = 1'b0; start_in = 1'b0; stop_in = 1'b0;
        repeat (2) @(negedge clk_in);
        n_cmp++; if (running_out !== 1'b0) begin n_fail++; $display("FAIL rst_running got %0b want 0", running_out); end
        n_cmp++; if (throw_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b want 0", throw_valid_out); end
        n_cmp++; if ({throw_height_out, throw_ball_out, beat_index_out} !== 9'd0) begin n_fail++; $display("FAIL rst_data got %0h want 0", {throw_height_out, throw_ball_out, beat_index_out}); end
        n_cmp++; if ({hand_out, error_out} !== 2'b00) begin n_fail++; $display("FAIL rst_hand_err got %0b want 00", {hand_out, error_out}); end
        rst_in = 1'b1;
    endtask

    task automatic test_cascade3();
        do_start(pk(3, 0, 0, 0, 0), 3'd1, 3'd3);
        n_cmp++; if (running_out !== 1'b1) begin n_fail++; $display("FAIL c3_running got %0b want 1", running_out); end
        for (int k = 0; k < 7; k++) begin
            do_beat();
            n_cmp++; if (throw_valid_out !== 1'b1) begin n_fail++; $display("FAIL c3_valid[%0d] got %0b want 1", k, throw_valid_out); end
            n_cmp++; if (throw_height_out !== 3'd3) begin n_fail++; $display("FAIL c3_height[%0d] got %0d want 3", k, throw_height_out); end
            n_cmp++; if (throw_ball_out !== 3'(k % 3)) begin n_fail++; $display("FAIL c3_ball[%0d] got %0d want %0d", k, throw_ball_out, k % 3); end
            n_cmp++; if (hand_out !== ((k % 2 == 0) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL c3_hand[%0d] got %0b want %0b", k, hand_out, (k % 2 == 0)); end
            n_cmp++; if (beat_index_out !== 3'd0) begin n_fail++; $display("FAIL c3_index[%0d] got %0d want 0", k, beat_index_out); end
        end
        n_cmp++; if (error_out !== 1'b0) begin n_fail++; $display("FAIL c3_error got %0b want 0", error_out); end
    endtask

    task automatic test_441();
        int eh[9] = '{4, 4, 1, 4, 4, 1, 4, 4, 1};
        int eb[9] = '{0, 1, 2, 2, 0, 1, 1, 2, 0};
        do_start(pk(4, 4, 1, 0, 0), 3'd3, 3'd3);
        pattern_in = '0;
        pattern_length = 3'd1;
        for (int k = 0; k < 9; k++) begin
            do_beat();
            n_cmp++; if (throw_valid_out !== 1'b1) begin n_fail++; $display("FAIL p441_valid[%0d] got %0b want 1", k, throw_valid_out); end
            n_cmp++; if (throw_height_out !== 3'(eh[k])) begin n_fail++; $display("FAIL p441_height[%0d] got %0d want %0d", k, throw_height_out, eh[k]); end
            n_cmp++; if (throw_ball_out !== 3'(eb[k])) begin n_fail++; $display("FAIL p441_ball[%0d] got %0d want %0d", k, throw_ball_out, eb[k]); end
            n_cmp++; if (beat_index_out !== 3'(k % 3)) begin n_fail++; $display("FAIL p441_index[%0d] got %0d want %0d", k, beat_index_out, k % 3); end
        end
        n_cmp++; if (error_out !== 1'b0) begin n_fail++; $display("FAIL p441_error got %0b want 0", error_out); end
    endtask

    task automatic test_51();
        int eh[6] = '{5, 1, 5, 1, 5, 1};
        int eb[6] = '{0, 1, 1, 2, 2, 0};
        do_start(pk(5, 1, 0, 0, 0), 3'd2, 3'd3);
        for (int k = 0; k < 6; k++) begin
            do_beat();
            n_cmp++; if (throw_valid_out !== 1'b1) begin n_fail++; $display("FAIL p51_valid[%0d] got %0b want 1", k, throw_valid_out); end
            n_cmp++; if (throw_height_out !== 3'(eh[k])) begin n_fail++; $display("FAIL p51_height[%0d] got %0d want %0d", k, throw_height_out, eh[k]); end
            n_cmp++; if (throw_ball_out !== 3'(eb[k])) begin n_fail++; $display("FAIL p51_ball[%0d] got %0d want %0d", k, throw_ball_out, eb[k]); end
        end
    endtask

    task automatic test_error();
        do_start(pk(3, 0, 0, 0, 0), 3'd1, 3'd2);
        for (int k = 0; k < 2; k++) begin
            do_beat();
            n_cmp++; if (throw_ball_out !== 3'(k)) begin n_fail++; $display("FAIL err_ball[%0d] got %0d want %0d", k, throw_ball_out, k); end
            n_cmp++; if (throw_valid_out !== 1'b1) begin n_fail++; $display("FAIL err_valid[%0d] got %0b want 1", k, throw_valid_out); end
        end
        do_beat();
        n_cmp++; if (throw_valid_out !== 1'b0) begin n_fail++; $display("FAIL err_beat_valid got %0b want 0", throw_valid_out); end
        n_cmp++; if (error_out !== 1'b1) begin n_fail++; $display("FAIL err_flag got %0b want 1", error_out); end
        n_cmp++; if (running_out !== 1'b0) begin n_fail++; $display("FAIL err_running got %0b want 0", running_out); end
        n_cmp++; if (throw_height_out !== 3'd3) begin n_fail++; $display("FAIL err_height got %0d want 3", throw_height_out); end
        n_cmp++; if (throw_ball_out !== 3'd0) begin n_fail++; $display("FAIL err_ball got %0d want 0", throw_ball_out); end
        do_beat();
        n_cmp++; if (throw_valid_out !== 1'b0) begin n_fail++; $display("FAIL err_idle_valid got %0b want 0", throw_valid_out); end
        n_cmp++; if (error_out !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %0b want 1", error_out); end
        n_cmp++; if (throw_height_out !== 3'd3) begin n_fail++; $display("FAIL err_hold_height got %0d want 3", throw_height_out); end
    endtask

    task automatic test_start_controls();
        @(negedge clk_in);
        pattern_in = pk(3, 0, 0, 0, 0); pattern_length = 3'd1; num_balls_in = 3'd3;
        pattern_valid_in = 1'b1; start_in = 1'b1; new_beat = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0; new_beat = 1'b0;
        n_cmp++; if (running_out !== 1'b1) begin n_fail++; $display("FAIL sb_running got %0b want 1", running_out); end
        n_cmp++; if (throw_valid_out !== 1'b0) begin n_fail++; $display("FAIL sb_valid got %0b want 0", throw_valid_out); end
        n_cmp++; if (error_out !== 1'b0) begin n_fail++; $display("FAIL sb_err_clear got %0b want 0", error_out); end
        do_beat();
        n_cmp++; if ({throw_valid_out, throw_ball_out, beat_index_out, hand_out} !== {1'b1, 3'd0, 3'd0, 1'b1}) begin
            n_fail++; $display("FAIL sb_first got v%0b b%0d i%0d h%0b want v1 b0 i0 h1", throw_valid_out, throw_ball_out, beat_index_out, hand_out);
        end
        @(negedge clk_in);
        stop_in = 1'b1; start_in = 1'b1;
        @(negedge clk_in);
        stop_in = 1'b0; start_in = 1'b0;
        n_cmp++; if (running_out !== 1'b0) begin n_fail++; $display("FAIL stop_wins got %0b want 0", running_out); end
        @(negedge clk_in);
        pattern_valid_in = 1'b0; start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        n_cmp++; if (running_out !== 1'b0) begin n_fail++; $display("FAIL invalid_start got %0b want 0", running_out); end
        do_beat();
        n_cmp++; if (throw_valid_out !== 1'b0) begin n_fail++; $display("FAIL idle_beat got %0b want 0", throw_valid_out); end
    endtask

    task automatic test_stop_restart();
        int eh[6] = '{5, 0, 5, 0, 5, 5};
        int eb[6] = '{0, 0, 1, 0, 2, 0};
        int ev[6] = '{1, 0, 1, 0, 1, 1};
        do_start(pk(3, 0, 0, 0, 0), 3'd1, 3'd3);
        do_beat();
        do_beat();
        @(negedge clk_in);
        stop_in = 1'b1; new_beat = 1'b1;
        @(negedge clk_in);
        stop_in = 1'b0; new_beat = 1'b0;
        n_cmp++; if (running_out !== 1'b0) begin n_fail++; $display("FAIL sr_running got %0b want 0", running_out); end
        n_cmp++; if (throw_valid_out !== 1'b0) begin n_fail++; $display("FAIL sr_stop_beat got %0b want 0", throw_valid_out); end
        n_cmp++; if (throw_ball_out !== 3'd1) begin n_fail++; $display("FAIL sr_hold_ball got %0d want 1", throw_ball_out); end
        do_start(pk(5, 0, 5, 0, 5), 3'd5, 3'd3);
        for (int k = 0; k < 6; k++) begin
            do_beat();
            n_cmp++; if (throw_valid_out !== 1'(ev[k])) begin n_fail++; $display("FAIL sr_valid[%0d] got %0b want %0d", k, throw_valid_out, ev[k]); end
            n_cmp++; if (throw_height_out !== 3'(eh[k])) begin n_fail++; $display("FAIL sr_height[%0d] got %0d want %0d", k, throw_height_out, eh[k]); end
            n_cmp++; if (throw_ball_out !== 3'(eb[k])) begin n_fail++; $display("FAIL sr_ball[%0d] got %0d want %0d", k, throw_ball_out, eb[k]); end
            n_cmp++; if (beat_index_out !== 3'(k % 5)) begin n_fail++; $display("FAIL sr_index[%0d] got %0d want %0d", k, beat_index_out, k % 5); end
        end
        n_cmp++; if (error_out !== 1'b0) begin n_fail++; $display("FAIL sr_error got %0b want 0", error_out); end
    endtask

    task automatic test_reset_midrun();
        do_beat();
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        n_cmp++; if ({running_out, throw_valid_out, hand_out, error_out} !== 4'b0000) begin
            n_fail++; $display("FAIL mr_ctrl got %0b want 0000", {running_out, throw_valid_out, hand_out, error_out});
        end
        n_cmp++; if ({throw_height_out, throw_ball_out, beat_index_out} !== 9'd0) begin
            n_fail++; $display("FAIL mr_data got %0h want 0", {throw_height_out, throw_ball_out, beat_index_out});
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        do_beat();
        n_cmp++; if (running_out !== 1'b0) begin n_fail++; $display("FAIL mr_no_resume got %0b want 0", running_out); end
        n_cmp++; if (throw_valid_out !== 1'b0) begin n_fail++; $display("FAIL mr_no_throw got %0b want 0", throw_valid_out); end
        n_cmp++; if (throw_height_out !== 3'd0) begin n_fail++; $display("FAIL mr_height got %0d want 0", throw_height_out); end
    endtask

    initial begin
        test_reset();
        test_cascade3();
        test_441();
        test_51();
        test_error();
        test_start_controls();
        test_stop_restart();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
